// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 iterative HI/LO mul/div (MULT/MULTU/DIV/DIVU/MTHI/MTLO); in clk rst start op a b, out busy done hi lo
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] prod, p_nx, m_res;
  logic [WIDTH-1:0] d, a_r, ma, mb, q_res, r_res;
  logic [WIDTH:0] s, t, df;
  logic ismul, neg, rneg, dz, sg, an, bn, ge;
  assign busy = state != IDLE;
  always_comb begin
    sg = op == 3'd1 || op == 3'd3;
    an = sg & a[WIDTH-1];
    bn = sg & b[WIDTH-1];
    ma = an ? -a : a;
    mb = bn ? -b : b;
    s = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, d} : '0);
    t = prod[2*WIDTH-1:WIDTH-1];
    df = t - {1'b0, d};
    ge = t >= {1'b0, d};
    p_nx = ismul ? {s, prod[WIDTH-1:1]} : {ge ? df[WIDTH-1:0] : t[WIDTH-1:0], prod[WIDTH-2:0], ge};
    m_res = neg ? -p_nx : p_nx;
    q_res = dz ? '1 : neg ? -p_nx[WIDTH-1:0] : p_nx[WIDTH-1:0];
    r_res = dz ? a_r : rneg ? -p_nx[2*WIDTH-1:WIDTH] : p_nx[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      prod <= '0;
      d <= '0;
      a_r <= '0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
      ismul <= 1'b0;
      neg <= 1'b0;
      rneg <= 1'b0;
      dz <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (op inside {[3'd1:3'd4]}) begin
            state <= RUN;
            cnt <= CW'(WIDTH);
            ismul <= op <= 3'd2;
            neg <= an ^ bn;
            rneg <= an;
            dz <= b == '0;
            a_r <= a;
            d <= op <= 3'd2 ? ma : mb;
            prod <= {{WIDTH{1'b0}}, op <= 3'd2 ? mb : ma};
          end else if (op == 3'd5) hi <= a;
          else if (op == 3'd6) lo <= a;
        end
        RUN: begin
          prod <= p_nx;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= FIN;
            done <= 1'b1;
            {hi, lo} <= ismul ? m_res : {r_res, q_res};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
